fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16, the number of predictor entries; the value SHALL be a power of two, 2..256.
REQ-003 SHALL have port clk, input, 1, the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port StallF, input, 1, holding PCF for this cycle (data hazard).
REQ-006 SHALL have port PCSrcE, input, 1, a mispredict redirect request from Execute.
REQ-007 SHALL have port PCTargetE, input, 32, the correct next PC when PCSrcE=1.
REQ-008 SHALL have port BranchE, input, 1, marking a resolved branch or jump in Execute that updates the predictor.
REQ-009 SHALL have port BranchTakenE, input, 1, the actual outcome of the resolved branch.
REQ-010 SHALL have port PCE, input, 32, the PC of the resolved branch.
REQ-011 SHALL have port BranchTargetE, input, 32, the actual target of the resolved branch.
REQ-012 SHALL have port imem_addr, output, 32, the instruction memory address, equal to PCF.
REQ-013 SHALL have port imem_rdata, input, 32, asynchronous-read instruction memory data.
REQ-014 SHALL have port instruction, output, 32, the fetched instruction, equal to imem_rdata.
REQ-015 SHALL have port PCF, output, 32, the current fetch PC (register).
REQ-016 SHALL have port PCPlus4F, output, 32, PCF+4.
REQ-017 SHALL have port TakenF, output, 1, the predicted-taken flag for the instruction at PCF.

Function
REQ-018 SHALL drive PCPlus4F as PCF+4 modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-019 SHALL select the next PCF in priority order: rst -> RESET_PC; PCSrcE -> PCTargetE; StallF -> hold; TakenF -> predicted target; otherwise PCPlus4F.
REQ-020 SHALL let a redirect (PCSrcE=1) override StallF in the same cycle.
REQ-021 SHALL implement a direct-mapped BTB with IDX=log2(BTB_ENTRIES), index PC[IDX+1:2], tag PC[31:IDX+2], and per-entry valid bit, 32-bit target and 2-bit saturating counter.
REQ-022 SHALL perform the lookup combinationally on PCF: hit = valid && tag match; TakenF = hit && counter[1]; the predicted target SHALL be the entry's target.
REQ-023 SHALL apply the BTB update at the rising edge when BranchE=1, indexed and tagged from PCE.
REQ-024 SHALL, on an update hit, increment the counter when taken and decrement it when not taken, saturating at 2'b11 and 2'b00, and overwrite the target only when taken.
REQ-025 SHALL, on an update miss with BranchTakenE=1, allocate or replace the entry with valid=1, the new tag, target=BranchTargetE and counter=2'b10.
REQ-026 SHALL NOT allocate on an update miss with BranchTakenE=0.
REQ-027 SHALL make a lookup at the same index as a same-cycle update return the pre-update contents (no bypass).
REQ-028 SHALL apply BTB updates regardless of StallF.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, load PCF=RESET_PC, clear all valid bits and set all counters to 2'b01, overriding every other input.
REQ-030 SHALL, in the first cycle after reset, drive TakenF=0, PCF=RESET_PC and PCPlus4F=RESET_PC+4.
REQ-031 SHALL discard any BTB update presented in the same cycle as rst=1.

Configuration
REQ-032 SHALL, with macro FETCH_BTB_PREDICT_EN defined, implement the BTB and prediction as in REQ-021..REQ-028.
REQ-033 SHALL, with FETCH_BTB_PREDICT_EN undefined, contain no BTB storage, tie TakenF=0, ignore BranchE, BranchTakenE, PCE and BranchTargetE, and use next PC = PCSrcE ? PCTargetE : StallF ? hold : PCPlus4F.

Verification
REQ-034 SHALL be verified by: reset with RESET_PC=0, no stall, 4 cycles -> PCF sequence 0,4,8,C; TakenF=0 throughout.
REQ-035 SHALL be verified by: StallF=1 for 2 cycles at PCF=8 -> PCF holds 8, then advances to C once StallF=0.
REQ-036 SHALL be verified by: StallF=1 and PCSrcE=1 with PCTargetE=0x100 together -> next PCF=0x100.
REQ-037 SHALL be verified by: BranchE=1, BranchTakenE=1, PCE=0x10, BranchTargetE=0x80, then PCF reaches 0x10 -> TakenF=1 and next PCF=0x80; with the macro undefined -> TakenF=0 and next PCF=0x14.
REQ-038 SHALL be verified by: two not-taken updates at PCE=0x10 after allocation -> counter goes 10->01->00, TakenF=0 at 0x10; the entry stays valid.
REQ-039 SHALL be verified by: PCTargetE=0xFFFF_FFFC redirect -> PCPlus4F=0, next PCF=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and an optional
// direct-mapped branch target buffer with 2-bit saturating counters.
//
// Optional feature macro: FETCH_BTB_PREDICT_EN
//   defined   -> BTB lookup on PCF drives TakenF and the predicted next PC;
//                resolved branches from Execute train the BTB.
//   undefined -> no BTB storage, TakenF tied low, branch inputs ignored.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   StallF          hold PCF this cycle
//   PCSrcE          redirect request from Execute (overrides StallF)
//   PCTargetE       redirect target
//   BranchE         resolved branch/jump in Execute (predictor update)
//   BranchTakenE    resolved outcome
//   PCE             PC of the resolved branch
//   BranchTargetE   resolved target
//   imem_addr       instruction memory address (= PCF)
//   imem_rdata      asynchronous instruction memory read data
//   instruction     fetched instruction (= imem_rdata)
//   PCF             current fetch PC
//   PCPlus4F        PCF + 4 (wraps modulo 2^32)
//   TakenF          predicted-taken flag for the instruction at PCF
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        BranchE,
    input  logic        BranchTakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] BranchTargetE,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        TakenF
);

    logic [31:0] pred_target;
    logic [31:0] next_pc;

    assign imem_addr   = PCF;
    assign instruction = imem_rdata;
    assign PCPlus4F    = PCF + 32'd4;

`ifdef FETCH_BTB_PREDICT_EN
    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [31:0]            btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             rd_hit;
    logic             wr_hit;
    logic             unused_pce_lsb;

    assign rd_idx = PCF[IDX+1:2];
    assign rd_tag = PCF[31:IDX+2];
    assign wr_idx = PCE[IDX+1:2];
    assign wr_tag = PCE[31:IDX+2];
    assign unused_pce_lsb = ^PCE[1:0];

    // Lookup reads the stored contents directly, so a same-index update this
    // cycle is only visible from the next cycle on.
    assign rd_hit      = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign wr_hit      = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
    assign TakenF      = rd_hit && btb_ctr[rd_idx][1];
    assign pred_target = btb_target[rd_idx];

    // Valid bits and counters: reset to empty / weakly-not-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_ctr[i] <= 2'b01;
            end
        end else if (BranchE) begin
            if (wr_hit) begin
                if (BranchTakenE) begin
                    if (btb_ctr[wr_idx] != 2'b11) btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'b01;
                end else begin
                    if (btb_ctr[wr_idx] != 2'b00) btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'b01;
                end
            end else if (BranchTakenE) begin
                btb_valid[wr_idx] <= 1'b1;
                btb_ctr[wr_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target payload: written only by taken updates (allocate or refresh).
    always_ff @(posedge clk) begin
        if (!rst && BranchE && BranchTakenE) begin
            btb_target[wr_idx] <= BranchTargetE;
            if (!wr_hit) btb_tag[wr_idx] <= wr_tag;
        end
    end
`else
    logic unused_branch_inputs;

    assign unused_branch_inputs = ^{BranchE, BranchTakenE, PCE, BranchTargetE};
    assign TakenF      = 1'b0;
    assign pred_target = 32'h0000_0000;
`endif

    // Next-PC priority: redirect, stall, prediction, sequential.
    always_comb begin
        next_pc = PCPlus4F;
        if (PCSrcE) begin
            next_pc = PCTargetE;
        end else if (StallF) begin
            next_pc = PCF;
        end else if (TakenF) begin
            next_pc = pred_target;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            PCF <= RESET_PC;
        end else begin
            PCF <= next_pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver updates a behavioural model
// and queues the outputs expected each cycle; a monitor compares on negedge.
module tb_fetch_stage;

    localparam int unsigned N        = 16;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
`ifdef FETCH_BTB_PREDICT_EN
    localparam bit          PRED     = 1'b1;
`else
    localparam bit          PRED     = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        BranchE;
    logic        BranchTakenE;
    logic [31:0] PCE;
    logic [31:0] BranchTargetE;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        TakenF;

    fetch_stage #(.RESET_PC(RST_PC), .BTB_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .BranchE(BranchE), .BranchTakenE(BranchTakenE),
        .PCE(PCE), .BranchTargetE(BranchTargetE), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instruction(instruction), .PCF(PCF),
        .PCPlus4F(PCPlus4F), .TakenF(TakenF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] pc4;
        logic        taken;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: PC plus a table of predictor entries.
    logic [31:0] m_pc;
    bit          known = 1'b0;
    bit          m_valid  [N];
    int unsigned m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % N;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    function automatic bit model_taken(input logic [31:0] pc);
        int unsigned i;
        i = idx_of(pc);
        return PRED && m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents PC outputs; compare against queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("PCF", PCF, e.pcf);
                check("PCPlus4F", PCPlus4F, e.pc4);
                check("TakenF", {31'b0, TakenF}, {31'b0, e.taken});
                check("instruction", instruction, e.instr);
                check("imem_addr", imem_addr, e.pcf);
            end
        end
    end

    // One cycle: drive inputs, queue expected outputs, advance the model.
    task automatic step(input bit r, input bit st, input bit src, input logic [31:0] tgt,
                        input bit br, input bit tk, input logic [31:0] pce, input logic [31:0] bt);
        exp_t        e;
        logic [31:0] instr;
        logic [31:0] nxt;
        bit          ptk;
        int unsigned i;
        bit          hit;
        instr = 32'($urandom);
        rst = r; StallF = st; PCSrcE = src; PCTargetE = tgt;
        BranchE = br; BranchTakenE = tk; PCE = pce; BranchTargetE = bt;
        imem_rdata = instr;
        ptk = model_taken(m_pc);
        if (known) begin
            e.pcf = m_pc; e.pc4 = m_pc + 32'd4; e.taken = ptk; e.instr = instr;
            exp_q.push_back(e);
        end
        if (r) begin
            m_pc  = RST_PC;
            known = 1'b1;
            for (int k = 0; k < int'(N); k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
        end else begin
            if (src)      nxt = tgt;
            else if (st)  nxt = m_pc;
            else if (ptk) nxt = m_target[idx_of(m_pc)];
            else          nxt = m_pc + 32'd4;
            if (PRED && br) begin
                i   = idx_of(pce);
                hit = m_valid[i] && (m_tag[i] == tag_of(pce));
                if (hit) begin
                    if (tk) begin
                        m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                        m_target[i] = bt;
                    end else begin
                        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    end
                end else if (tk) begin
                    m_valid[i]  = 1'b1;
                    m_tag[i]    = tag_of(pce);
                    m_target[i] = bt;
                    m_ctr[i]    = 2;
                end
            end
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic redirect(input logic [31:0] t);
        step(0, 0, 1, t, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic train(input bit tk, input logic [31:0] pce, input logic [31:0] bt);
        step(0, 0, 0, 32'h0, 1, tk, pce, bt);
    endtask

    initial begin
        logic [31:0] tgt;
        logic [31:0] pce;
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        BranchE = 1'b0; BranchTakenE = 1'b0; PCE = '0; BranchTargetE = '0;
        imem_rdata = '0;
        @(posedge clk);
        #1;

        // Reset, then sequential fetch with a two-cycle stall at PC 8.
        step(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        idle(); idle();
        step(0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        idle(); idle();

        // Redirect wins over stall.
        step(0, 1, 1, 32'h100, 0, 0, 32'h0, 32'h0);
        idle();

        // Train a taken branch at 0x10 -> 0x80, then fetch through it.
        step(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        train(1, 32'h10, 32'h80);
        idle(); idle(); idle(); idle(); idle(); idle();

        // Two not-taken updates: 10 -> 01 -> 00, entry must stay valid.
        train(0, 32'h10, 32'h0);
        train(0, 32'h10, 32'h0);
        redirect(32'h10);
        idle(); idle();
        // Hit on a still-valid entry: counter 00 -> 01, still not predicted.
        train(1, 32'h10, 32'h90);
        redirect(32'h10);
        idle(); idle();
        train(1, 32'h10, 32'h90);
        redirect(32'h10);
        idle(); idle();

        // Update presented during reset is discarded.
        step(1, 0, 0, 32'h0, 1, 1, 32'h20, 32'h40);
        redirect(32'h20);
        idle(); idle();

        // Wrap of PC+4 at the top of the address space.
        redirect(32'hFFFF_FFFC);
        idle(); idle();

        // Randomised traffic over a small PC window to exercise aliasing.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                step(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
            end else begin
                tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 127)) << 2;
                pce = 32'($urandom_range(0, 127)) << 2;
                step(0, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 12, tgt,
                     $urandom_range(0, 99) < 40, $urandom_range(0, 1) == 1, pce,
                     32'($urandom_range(0, 127)) << 2);
            end
        end
        idle();

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
